syscall_read_string: RTL and testbench

- Input-side counterpart of the data memory's print-string service. The data memory walks a null-terminated string out of memory. This block streams characters in from a console byte source and stores them into data memory as a null-terminated, little-endian byte-packed string.
- Implements MIPS syscall 8 semantics: buffer address in a0, length in a1, at most a1-1 characters stored, then a null.
- Sits beside the data memory and drives its write port with byte enables, so no read-modify-write is needed.

---
 rtl/syscall_read_string.sv | 172 +++++++++++++++++
 tb/tb_syscall_read_string.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/syscall_read_string.sv
// rtl/syscall_read_string.sv - console-to-memory string reader (syscall 8), byte-enabled word writes
module syscall_read_string #(
    parameter int          ADDR_W  = 32,
    parameter logic [7:0]  NEWLINE = 8'h0A,
    parameter int          CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] a0,
    input  logic [ADDR_W-1:0] a1,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, NULLW, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] rem;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       word_buf;
    logic [3:0]        be_q;
    logic              final_q;
    logic              pend_null;
    logic [CNT_W-1:0]  count_q;

    logic [1:0]        lane;
    logic              accept;
    logic              term;
    logic [ADDR_W-1:0] rem_dec;

    assign lane    = ptr[1:0];
    assign accept  = (state == RECV) && char_valid;
    assign rem_dec = rem - ADDR_W'(1);
    // Stop on newline, or once only the slot reserved for the null remains.
    assign term    = accept && ((char_data == NEWLINE) || (rem_dec == ADDR_W'(1)));
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (a1 == '0)
                        state_next = DONE;
                    else if (a1 == ADDR_W'(1))
                        state_next = NULLW;
                    else
                        state_next = RECV;
                end
            end
            RECV: begin
                if (accept && (term || lane == 2'd3))
                    state_next = WRITE;
            end
            WRITE: begin
                if (final_q)
                    state_next = DONE;
                else if (pend_null)
                    state_next = NULLW;
                else
                    state_next = RECV;
            end
            NULLW:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            rem       <= '0;
            word_addr <= '0;
            word_buf  <= '0;
            be_q      <= '0;
            final_q   <= 1'b0;
            pend_null <= 1'b0;
            count_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= a0;
                        rem       <= a1;
                        count_q   <= '0;
                        word_buf  <= '0;
                        be_q      <= '0;
                        final_q   <= 1'b0;
                        pend_null <= 1'b0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        word_buf[8*lane +: 8] <= char_data;
                        be_q[lane]            <= 1'b1;
                        word_addr             <= {ptr[ADDR_W-1:2], 2'b00};
                        rem                   <= rem_dec;
                        if (count_q != '1)
                            count_q <= count_q + CNT_W'(1);
                        final_q   <= term && (lane != 2'd3);
                        pend_null <= term && (lane == 2'd3);
                        // The null rides in the same word when a lane is left; its data byte is already zero.
                        if (term && (lane != 2'd3)) begin
                            be_q[lane + 2'd1] <= 1'b1;
                            ptr               <= ptr + ADDR_W'(2);
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                end
                WRITE: begin
                    word_buf <= '0;
                    be_q     <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        char_ready = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            RECV: begin
                char_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = word_buf;
                mem_be    = be_q;
                busy      = 1'b1;
            end
            NULLW: begin
                mem_write = 1'b1;
                mem_addr  = {ptr[ADDR_W-1:2], 2'b00};
                mem_be    = 4'b0001 << ptr[1:0];
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_syscall_read_string.sv
// tb/tb_syscall_read_string.sv - directed scoreboard bench for syscall_read_string
module tb_syscall_read_string;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        busy;
    logic        done;
    logic [15:0] count;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];

    syscall_read_string dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a0         (a0),
        .a1         (a1),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_write)
            obs_q.push_back('{addr: mem_addr, data: mem_wdata, be: mem_be});
    end

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        exp_q.push_back('{addr: addr, data: data, be: be});
    endtask

    task automatic drain(input string tag);
        wr_t e, o;
        logic [31:0] mask;
        chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            mask = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
            chk({tag, "_addr"}, 64'(o.addr), 64'(e.addr));
            chk({tag, "_be"}, 64'(o.be), 64'(e.be));
            chk({tag, "_wdata"}, 64'(o.data & mask), 64'(e.data & mask));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Runs one request; called at a negedge, returns at the negedge after done.
    task automatic run_scn(input string tag, input logic [31:0] addr, input logic [31:0] len,
                           input string s, input bit gaps, input bit stray,
                           input int exp_acc, input int exp_cnt, input int exp_lat, input int exp_done);
        int acc = 0;
        int done_cyc = -1;
        int last_acc = -1;
        logic [15:0] cnt = '0;
        start = 1'b1;
        a0    = addr;
        a1    = len;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                cnt = count;
                break;
            end
            start = stray && (cyc == 3);
            if (stray && cyc == 3) begin
                a0 = 32'hDEAD0000;
                a1 = 32'd3;
            end
            char_valid = (acc < s.len()) && (!gaps || (cyc % 4 == 0) || (cyc % 4 == 3));
            char_data  = (acc < s.len()) ? s[acc] : 8'h00;
            if (char_valid && char_ready) begin
                last_acc = cyc;
                acc++;
            end
            @(negedge clk);
        end
        char_valid = 1'b0;
        start      = 1'b0;
        chk({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
        chk({tag, "_accepted"}, 64'(acc), 64'(exp_acc));
        chk({tag, "_count"}, 64'(cnt), 64'(exp_cnt));
        if (exp_lat >= 0)
            chk({tag, "_latency"}, 64'(done_cyc - last_acc), 64'(exp_lat));
        if (exp_done >= 0)
            chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'({done, busy}), 64'd0);
        drain(tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        a0         = '0;
        a1         = '0;
        char_valid = 1'b0;
        char_data  = '0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", 64'({char_ready, mem_write, mem_be, busy, done}), 64'd0);
        chk("reset_data", {mem_addr, mem_wdata}, 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        push_exp(32'h10010000, 32'h000A6968, 4'b1111);
        run_scn("aligned", 32'h10010000, 32'd16, "hi\n", 1'b0, 1'b0, 3, 3, 2, -1);

        push_exp(32'h10010000, 32'h64636261, 4'b1111);
        push_exp(32'h10010004, 32'h00000000, 4'b0001);
        run_scn("limit", 32'h10010000, 32'd5, "abcdefg", 1'b0, 1'b0, 4, 4, 3, -1);

        push_exp(32'h10010000, 32'h79780000, 4'b1100);
        push_exp(32'h10010004, 32'h0000000A, 4'b0011);
        run_scn("unaligned", 32'h10010002, 32'd8, "xy\n", 1'b0, 1'b0, 3, 3, 2, -1);

        run_scn("len0", 32'h10010000, 32'd0, "zz", 1'b0, 1'b0, 0, 0, -1, 0);

        push_exp(32'h10010000, 32'h00000000, 4'b1000);
        run_scn("len1", 32'h10010003, 32'd1, "zz", 1'b0, 1'b0, 0, 0, -1, 1);

        push_exp(32'h10010000, 32'h6C6C6568, 4'b1111);
        push_exp(32'h10010004, 32'h00000A6F, 4'b0111);
        run_scn("gaps_stray", 32'h10010000, 32'd16, "hello\n", 1'b1, 1'b1, 6, 6, 2, -1);

        // Abort after two bytes of a word have been taken.
        start = 1'b1;
        a0    = 32'h10010000;
        a1    = 32'd16;
        @(negedge clk);
        start      = 1'b0;
        char_valid = 1'b1;
        char_data  = "a";
        @(negedge clk);
        char_data  = "b";
        @(negedge clk);
        char_valid = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        chk("midreset_ctrl", 64'({char_ready, mem_write, mem_be, busy, done}), 64'd0);
        chk("midreset_data", {mem_addr, mem_wdata}, 64'd0);
        chk("midreset_count", 64'(count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        drain("midreset");

        push_exp(32'h10010000, 32'h000A6968, 4'b1111);
        run_scn("after_reset", 32'h10010000, 32'd16, "hi\n", 1'b0, 1'b0, 3, 3, 2, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
